// File: rtl/axis_y_serializer.sv
// rtl/axis_y_serializer.sv - wide result word to narrow AXIS beat serializer
module axis_y_serializer #(
  parameter int R     = 8,
  parameter int W_Y   = 19,
  parameter int W_OUT = 8
) (
  input  logic               clk,
  input  logic               rst,
  output logic               s_axis_y_tready,
  input  logic               s_axis_y_tvalid,
  input  logic [R*W_Y-1:0]   s_axis_y_tdata,
  input  logic               m_axis_tready,
  output logic               m_axis_tvalid,
  output logic [W_OUT-1:0]   m_axis_tdata,
  output logic               m_axis_tlast
);

  localparam int W_IN = R * W_Y;
  localparam int N    = (W_IN + W_OUT - 1) / W_OUT;
  localparam int CW   = (N > 1) ? $clog2(N) : 1;

  localparam logic [CW-1:0] LAST_BEAT = CW'(N - 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;

  logic [0:0]    state;
  logic [CW-1:0] cnt;
  logic [W_IN-1:0] sr;

  logic in_hs;
  logic out_hs;

  // Outputs come straight from registered state; a new word is accepted when
  // idle or in the same cycle the final beat of the current word leaves.
  always_comb begin
    m_axis_tvalid   = (state == SEND);
    m_axis_tlast    = (state == SEND) && (cnt == LAST_BEAT);
    m_axis_tdata    = sr[W_OUT-1:0];
    s_axis_y_tready = (state == IDLE) || (m_axis_tvalid && m_axis_tready && m_axis_tlast);
    in_hs           = s_axis_y_tvalid && s_axis_y_tready;
    out_hs          = m_axis_tvalid && m_axis_tready;
  end

  // Load on input handshake, shift one beat per output handshake; the right
  // shift zero-fills, which also pads the top of the final beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      sr    <= '0;
    end else if (in_hs) begin
      sr    <= s_axis_y_tdata;
      cnt   <= '0;
      state <= SEND;
    end else if (out_hs) begin
      if (m_axis_tlast) begin
        state <= IDLE;
      end else begin
        sr  <= sr >> W_OUT;
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_axis_y_serializer.sv
// tb/tb_axis_y_serializer.sv - scoreboard bench for axis_y_serializer
module tb_axis_y_serializer;

  typedef struct {
    logic [7:0] d;
    logic       l;
  } beat_t;

  logic         clk = 1'b0;
  logic         rst;
  logic [151:0] s_data;
  logic [2:0]   s_valid;
  logic [2:0]   s_ready;
  logic [2:0]   m_ready;
  logic [2:0]   m_valid;
  logic [2:0]   m_last;
  logic [7:0]   md0, md1, md2;

  beat_t q[$];
  beat_t stage[$];
  int    stage_n[$];
  int    n_cmp = 0;
  int    n_err = 0;
  int    sel = 0;
  bit    accepted = 0;
  bit    rand_ready = 0;

  always #5 clk = ~clk;

  // R=2, W_Y=12: N=3, exact fit
  axis_y_serializer #(.R(2), .W_Y(12), .W_OUT(8)) u_a (
    .clk(clk), .rst(rst),
    .s_axis_y_tready(s_ready[0]), .s_axis_y_tvalid(s_valid[0]), .s_axis_y_tdata(s_data[23:0]),
    .m_axis_tready(m_ready[0]), .m_axis_tvalid(m_valid[0]), .m_axis_tdata(md0), .m_axis_tlast(m_last[0])
  );

  // R=2, W_Y=10: W_IN=20, N=3 with zero-filled top nibble
  axis_y_serializer #(.R(2), .W_Y(10), .W_OUT(8)) u_b (
    .clk(clk), .rst(rst),
    .s_axis_y_tready(s_ready[1]), .s_axis_y_tvalid(s_valid[1]), .s_axis_y_tdata(s_data[19:0]),
    .m_axis_tready(m_ready[1]), .m_axis_tvalid(m_valid[1]), .m_axis_tdata(md1), .m_axis_tlast(m_last[1])
  );

  // defaults: W_IN=152, N=19
  axis_y_serializer u_c (
    .clk(clk), .rst(rst),
    .s_axis_y_tready(s_ready[2]), .s_axis_y_tvalid(s_valid[2]), .s_axis_y_tdata(s_data),
    .m_axis_tready(m_ready[2]), .m_axis_tvalid(m_valid[2]), .m_axis_tdata(md2), .m_axis_tlast(m_last[2])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic stage_word(input logic [7:0] bs[$]);
    beat_t b;
    for (int i = 0; i < bs.size(); i++) begin
      b.d = bs[i];
      b.l = (i == bs.size() - 1);
      stage.push_back(b);
    end
    stage_n.push_back(bs.size());
  endtask

  task automatic tick();
    logic       v, r, l, exp_sr;
    logic [7:0] d;
    int         k;
    @(negedge clk);
    d = (sel == 0) ? md0 : (sel == 1) ? md1 : md2;
    v = m_valid[sel];
    l = m_last[sel];
    r = s_ready[sel];
    accepted = 0;
    if (!rst) begin
      exp_sr = (q.size() == 0) || (m_ready[sel] && q[0].l);
      chk("m_tvalid", {31'd0, v}, {31'd0, q.size() != 0});
      chk("s_tready", {31'd0, r}, {31'd0, exp_sr});
      if (q.size() != 0) begin
        chk("m_tdata", {24'd0, d}, {24'd0, q[0].d});
        chk("m_tlast", {31'd0, l}, {31'd0, q[0].l});
        if (m_ready[sel]) void'(q.pop_front());
      end
      if (s_valid[sel] && exp_sr && stage_n.size() != 0) begin
        accepted = 1;
        k = stage_n.pop_front();
        repeat (k) q.push_back(stage.pop_front());
      end
    end
    @(posedge clk);
    #1;
    if (rand_ready) m_ready[sel] = 1'($urandom_range(0, 1));
  endtask

  task automatic offer(input logic [151:0] w);
    int t;
    s_data = w;
    s_valid[sel] = 1'b1;
    t = 0;
    do begin
      tick();
      t++;
    end while (!accepted && t < 200);
    chk("accept_timeout", {31'd0, accepted}, 32'd1);
  endtask

  task automatic drain();
    int t;
    s_valid = '0;
    t = 0;
    while (q.size() != 0 && t < 500) begin
      tick();
      t++;
    end
    chk("drain_timeout", q.size(), 32'd0);
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    s_valid = '0;
    tick();
    tick();
    chk("rst_tvalid", {29'd0, m_valid}, 32'd0);
    chk("rst_tlast", {29'd0, m_last}, 32'd0);
    chk("rst_tdata", {8'd0, md2, md1, md0}, 32'd0);
    q.delete();
    stage.delete();
    stage_n.delete();
    rst = 1'b0;
  endtask

  initial begin
    logic [7:0]   bs[$];
    logic [159:0] tmp;
    logic [151:0] w;

    rst = 1'b1;
    s_valid = '0;
    m_ready = 3'b111;
    s_data = '0;
    do_reset();
    tick();

    // exact-fit word, LSB-first
    sel = 0;
    bs = '{8'hEF, 8'hCD, 8'hAB};
    stage_word(bs);
    offer(152'hABCDEF);
    drain();

    // partial last beat zero-filled; bits above W_IN on the bus are ignored
    sel = 1;
    bs = '{8'hFF, 8'hFF, 8'h0F};
    stage_word(bs);
    offer({152{1'b1}});
    drain();

    // back-to-back words with no bubble
    sel = 0;
    bs = '{8'h56, 8'h34, 8'h12};
    stage_word(bs);
    bs = '{8'hBC, 8'h9A, 8'h78};
    stage_word(bs);
    offer(152'h123456);
    offer(152'h789ABC);
    drain();

    // random downstream stalls
    rand_ready = 1;
    bs = '{8'h11, 8'h22, 8'h33};
    stage_word(bs);
    bs = '{8'hC3, 8'hB2, 8'hA1};
    stage_word(bs);
    offer(152'h332211);
    offer(152'hA1B2C3);
    drain();
    rand_ready = 0;
    m_ready = 3'b111;

    // reset mid-word after beat 1
    bs = '{8'hEF, 8'hCD, 8'hAB};
    stage_word(bs);
    offer(152'hABCDEF);
    s_valid = '0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk("midrst_tvalid", {31'd0, m_valid[0]}, 32'd0);
    chk("midrst_tlast", {31'd0, m_last[0]}, 32'd0);
    chk("midrst_s_tready", {31'd0, s_ready[0]}, 32'd1);
    q.delete();
    rst = 1'b0;
    bs = '{8'h01, 8'h00, 8'h00};
    stage_word(bs);
    offer(152'h000001);
    drain();

    // default parameters, random 152-bit words
    sel = 2;
    for (int n = 0; n < 2; n++) begin
      for (int i = 0; i < 5; i++) tmp[i*32 +: 32] = $urandom;
      w = tmp[151:0];
      bs.delete();
      for (int i = 0; i < 19; i++) bs.push_back(w[i*8 +: 8]);
      stage_word(bs);
      rand_ready = (n == 1);
      offer(w);
      drain();
    end
    rand_ready = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/axis_y_serializer.md
AXIS_Y_SERIALIZER -- requirements
Module: axis_y_serializer

Interface
REQ-001 SHALL have parameter R, default 8: number of result elements per input word.
REQ-002 SHALL have parameter W_Y, default 19: width of each result element.
REQ-003 SHALL have parameter W_OUT, default 8: output beat width.
REQ-004 SHALL derive W_IN = R*W_Y and N = ceil(W_IN/W_OUT), beats per word; W_IN >= W_OUT is required.
REQ-005 SHALL have port clk, input, 1: single clock; all logic is rising-edge.
REQ-006 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-007 SHALL have port s_axis_y_tready, output, 1: wide word accepted when high with tvalid.
REQ-008 SHALL have port s_axis_y_tvalid, input, 1: wide word valid.
REQ-009 SHALL have port s_axis_y_tdata, input, W_IN: packed result vector; element r occupies bits [r*W_Y +: W_Y].
REQ-010 SHALL have port m_axis_tready, input, 1: downstream (UART TX) ready.
REQ-011 SHALL have port m_axis_tvalid, output, 1: beat valid.
REQ-012 SHALL have port m_axis_tdata, output, W_OUT: beat payload.
REQ-013 SHALL have port m_axis_tlast, output, 1: high on the final beat of a word.

Function
REQ-014 SHALL implement two states: IDLE (no word held) and SEND (word held, beats pending).
REQ-015 SHALL hold a W_IN-bit shift register and a beat counter of width clog2(N), minimum 1.
REQ-016 SHALL drive s_axis_y_tready = (state==IDLE) | (m_axis_tvalid & m_axis_tready & m_axis_tlast), combinationally.
REQ-017 SHALL, on input handshake, load the shift register with s_axis_y_tdata, clear the counter, and enter SEND.
REQ-018 SHALL emit beats LSB-first: beat i = word bits [i*W_OUT +: W_OUT].
REQ-019 SHALL zero-fill bits at and above W_IN in the final beat.
REQ-020 SHALL drive m_axis_tdata from the low W_OUT bits of the shift register, with no combinational path from s_axis_y_tdata.
REQ-021 SHALL drive m_axis_tvalid = (state==SEND).
REQ-022 SHALL drive m_axis_tlast = (state==SEND) & (counter==N-1).
REQ-023 SHALL, on a non-last output handshake, shift the register right by W_OUT with zero fill and increment the counter.
REQ-024 SHALL, on a last-beat handshake with s_axis_y_tvalid high, load the next word in the same cycle and stay in SEND, giving back-to-back words with no bubble.
REQ-025 SHALL, on a last-beat handshake with s_axis_y_tvalid low, return to IDLE.
REQ-026 SHALL hold m_axis_tdata, m_axis_tvalid and m_axis_tlast stable while m_axis_tvalid is high and m_axis_tready is low (AXIS stability).
REQ-027 SHALL have first-beat latency of one cycle: a word accepted at edge k is presented as beat 0 after edge k.
REQ-028 SHALL sustain a peak throughput of one beat per cycle and one word per N cycles.
REQ-029 SHALL, when N==1, assert m_axis_tlast on every beat and behave as a 1-deep register slice.
REQ-030 SHALL ignore s_axis_y_tvalid while in SEND before the last-beat handshake; tready is low, so the upstream skid buffer holds the word.

Reset
REQ-031 SHALL, with rst high at a rising edge, go to IDLE, clear the counter and clear the shift register.
REQ-032 SHALL drive m_axis_tvalid=0 and m_axis_tlast=0 during reset.
REQ-033 SHALL drive m_axis_tdata=0 during reset.
REQ-034 SHALL drive s_axis_y_tready=1 in the first cycle after reset.
REQ-035 SHALL, on reset mid-word, discard the remaining beats and emit no partial tlast.

Verification
REQ-036 SHALL pass: R=2, W_Y=12 (N=3), word 0xABCDEF, tready held 1 -> beats EF, CD, AB on consecutive cycles; tlast only on AB.
REQ-037 SHALL pass: R=2, W_Y=10 (W_IN=20), word 0xFFFFF -> beats FF, FF, 0F; upper nibble of the last beat is zero.
REQ-038 SHALL pass: back-to-back words 0x123456 then 0x789ABC with s_tvalid held -> 56,34,12,BC,9A,78 with no idle cycle; s_tready high only in the tlast cycles.
REQ-039 SHALL pass: random m_axis_tready deassertion -> tdata/tlast held while stalled; byte sequence and tlast positions unchanged.
REQ-040 SHALL pass: rst asserted after beat 1 of 0xABCDEF -> tvalid=0 on the next cycle, s_tready=1; a new word 0x000001 then yields 01, 00, 00.
REQ-041 SHALL pass: defaults (R=8, W_Y=19, N=19) with a random 152-bit word -> 19 beats, beat 18 = {0, bits[151:144]}, tlast only on beat 18.
